// File: rtl/led_scan_ctrl.sv
// LED panel read-side sequencer: walks row/plane/column through the frame buffer,
// drives the panel strobes with binary-coded-modulation timing and owns the buffer swap.
module led_scan_ctrl #(
  parameter int DATA_WIDTH  = 64,
  parameter int COL_BITS    = 6,
  parameter int ROW_BITS    = 4,
  parameter int PLANES      = 8,
  parameter int BASE_CYCLES = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic                            mem_re,
  output logic [ROW_BITS+COL_BITS:0]      mem_addr,
  input  logic [DATA_WIDTH-1:0]           mem_dout,
  output logic [DATA_WIDTH-1:0]           pix_data,
  output logic                            pix_valid,
  output logic [3:0]                      plane,
  output logic                            sclk,
  output logic                            lat,
  output logic                            oe_n,
  output logic [ROW_BITS-1:0]             row_addr,
  input  logic                            swap_req,
  output logic                            swap_ack,
  output logic                            buf_sel,
  output logic                            frame_start
);

  localparam int AW    = 1 + ROW_BITS + COL_BITS;
  localparam int CNT_W = $clog2(BASE_CYCLES + 1) + 16;
  localparam logic [CNT_W-1:0] BASE_W = CNT_W'(BASE_CYCLES);

  localparam logic [1:0] S_SHIFT = 2'd0;
  localparam logic [1:0] S_TAIL  = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;
  localparam logic [1:0] S_DISP  = 2'd3;

  // Sequencer registers describe the cycle about to be issued; output registers
  // are loaded from that description on the edge that starts the cycle.
  logic [1:0]            state_q, state_d;
  logic                  phase_q, phase_d;
  logic [COL_BITS-1:0]   col_q, col_d;
  logic [ROW_BITS-1:0]   row_q, row_d;
  logic [3:0]            plane_q, plane_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  buf_sel_q, buf_sel_d;
  logic                  swap_pending_q, swap_pending_d;

  logic                  mem_re_q, mem_re_d;
  logic [AW-1:0]         mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] pix_data_q, pix_data_d;
  logic                  pix_valid_q, pix_valid_d;
  logic [3:0]            plane_out_q, plane_out_d;
  logic                  sclk_q, sclk_d;
  logic                  lat_q, lat_d;
  logic                  oe_n_q, oe_n_d;
  logic [ROW_BITS-1:0]   row_addr_q, row_addr_d;
  logic                  swap_ack_q, swap_ack_d;
  logic                  frame_start_q, frame_start_d;

  logic                  first_read;
  logic                  swap_now;
  logic [CNT_W-1:0]      disp_last;

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    col_d          = col_q;
    row_d          = row_q;
    plane_d        = plane_q;
    cnt_d          = cnt_q;
    mem_re_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    pix_data_d     = pix_data_q;
    pix_valid_d    = 1'b0;
    plane_out_d    = plane_q;
    sclk_d         = 1'b0;
    lat_d          = 1'b0;
    oe_n_d         = 1'b1;
    row_addr_d     = row_addr_q;
    frame_start_d  = 1'b0;
    disp_last      = (BASE_W << plane_q) - CNT_W'(1);

    // The swap lands on the edge that issues the first read of a new frame.
    first_read     = (state_q == S_SHIFT) && !phase_q && (col_q == '0) &&
                     (row_q == '0) && (plane_q == 4'd0);
    swap_now       = first_read && swap_pending_q;
    buf_sel_d      = swap_now ? ~buf_sel_q : buf_sel_q;
    swap_ack_d     = swap_now;
    swap_pending_d = swap_req | (swap_pending_q & ~swap_now);

    case (state_q)
      S_SHIFT: begin
        if (!phase_q) begin
          mem_re_d      = 1'b1;
          mem_addr_d    = {buf_sel_d, row_q, col_q};
          sclk_d        = (col_q != '0);
          frame_start_d = first_read;
          phase_d       = 1'b1;
        end else begin
          pix_valid_d = 1'b1;
          pix_data_d  = mem_dout;
          phase_d     = 1'b0;
          col_d       = col_q + 1'b1;
          if (col_q == {COL_BITS{1'b1}}) state_d = S_TAIL;
        end
      end
      S_TAIL: begin
        sclk_d  = 1'b1;
        state_d = S_LATCH;
      end
      S_LATCH: begin
        lat_d      = 1'b1;
        row_addr_d = row_q;
        cnt_d      = '0;
        state_d    = S_DISP;
      end
      default: begin
        oe_n_d = 1'b0;
        if (cnt_q == disp_last) begin
          cnt_d   = '0;
          state_d = S_SHIFT;
          if (plane_q == 4'(PLANES - 1)) begin
            plane_d = 4'd0;
            row_d   = row_q + 1'b1;
          end else begin
            plane_d = plane_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_SHIFT;
      phase_q        <= 1'b0;
      col_q          <= '0;
      row_q          <= '0;
      plane_q        <= 4'd0;
      cnt_q          <= '0;
      buf_sel_q      <= 1'b0;
      swap_pending_q <= 1'b0;
      mem_re_q       <= 1'b0;
      mem_addr_q     <= '0;
      pix_data_q     <= '0;
      pix_valid_q    <= 1'b0;
      plane_out_q    <= 4'd0;
      sclk_q         <= 1'b0;
      lat_q          <= 1'b0;
      oe_n_q         <= 1'b1;
      row_addr_q     <= '0;
      swap_ack_q     <= 1'b0;
      frame_start_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      col_q          <= col_d;
      row_q          <= row_d;
      plane_q        <= plane_d;
      cnt_q          <= cnt_d;
      buf_sel_q      <= buf_sel_d;
      swap_pending_q <= swap_pending_d;
      mem_re_q       <= mem_re_d;
      mem_addr_q     <= mem_addr_d;
      pix_data_q     <= pix_data_d;
      pix_valid_q    <= pix_valid_d;
      plane_out_q    <= plane_out_d;
      sclk_q         <= sclk_d;
      lat_q          <= lat_d;
      oe_n_q         <= oe_n_d;
      row_addr_q     <= row_addr_d;
      swap_ack_q     <= swap_ack_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign mem_re      = mem_re_q;
  assign mem_addr    = mem_addr_q;
  assign pix_data    = pix_data_q;
  assign pix_valid   = pix_valid_q;
  assign plane       = plane_out_q;
  assign sclk        = sclk_q;
  assign lat         = lat_q;
  assign oe_n        = oe_n_q;
  assign row_addr    = row_addr_q;
  assign swap_ack    = swap_ack_q;
  assign buf_sel     = buf_sel_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Bench for led_scan_ctrl: small panel config, per-cycle comparison against a
// frame-level reference schedule built from row/plane/column loops.
module tb_led_scan_ctrl;

  localparam int DW   = 16;
  localparam int CB   = 2;
  localparam int RB   = 1;
  localparam int NP   = 2;
  localparam int BC   = 2;
  localparam int AW   = 1 + RB + CB;
  localparam int NCOL = 1 << CB;
  localparam int NROW = 1 << RB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic [3:0]    plane;
  logic          sclk, lat, oe_n;
  logic [RB-1:0] row_addr;
  logic          swap_req = 1'b0;
  logic          swap_ack, buf_sel, frame_start;

  always #5 clk = ~clk;

  // RAM contents: word at address a holds a*3, presented from the registered read address.
  assign mem_dout = DW'(mem_addr) * DW'(3);

  led_scan_ctrl #(
    .DATA_WIDTH(DW), .COL_BITS(CB), .ROW_BITS(RB), .PLANES(NP), .BASE_CYCLES(BC)
  ) dut (
    .clk(clk), .rst(rst), .mem_re(mem_re), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .pix_data(pix_data), .pix_valid(pix_valid), .plane(plane), .sclk(sclk), .lat(lat),
    .oe_n(oe_n), .row_addr(row_addr), .swap_req(swap_req), .swap_ack(swap_ack),
    .buf_sel(buf_sel), .frame_start(frame_start)
  );

  typedef struct packed {
    logic       re;
    logic [7:0] col;
    logic       pv;
    logic       sck;
    logic       lt;
    logic       oen;
    logic       fs;
  } ent_t;

  ent_t q[$];
  int   nxt_row, nxt_plane, m_row, m_plane;
  bit   m_buf, m_pend, last_oen;
  int   exp_addr, exp_data, exp_row;
  int   n_pass, n_checks, acks_seen, frame_len;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic ent_t mk(bit re, int col, bit pv, bit sck, bit lt, bit oen, bit fs);
    ent_t e;
    e.re = re; e.col = 8'(col); e.pv = pv; e.sck = sck; e.lt = lt; e.oen = oen; e.fs = fs;
    return e;
  endfunction

  // One (row, plane) slot: read/valid pairs per column, tail, latch, then display.
  function automatic void gen_seg();
    m_row   = nxt_row;
    m_plane = nxt_plane;
    for (int c = 0; c < NCOL; c++) begin
      q.push_back(mk(1, c, 0, c != 0, 0, 1, c == 0 && m_row == 0 && m_plane == 0));
      q.push_back(mk(0, c, 1, 0, 0, 1, 0));
    end
    q.push_back(mk(0, 0, 0, 1, 0, 1, 0));
    q.push_back(mk(0, 0, 0, 0, 1, 1, 0));
    for (int d = 0; d < (BC << m_plane); d++) q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    if (nxt_plane < NP - 1) nxt_plane++;
    else begin
      nxt_plane = 0;
      nxt_row   = (nxt_row + 1) % NROW;
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    nxt_row = 0; nxt_plane = 0; m_row = 0; m_plane = 0;
    m_buf = 0; m_pend = 0; last_oen = 1;
    exp_addr = 0; exp_data = 0; exp_row = 0;
  endfunction

  function automatic bit next_is_fs();
    if (q.size() == 0) return (nxt_row == 0 && nxt_plane == 0);
    return q[0].fs;
  endfunction

  task automatic cycle(input bit req);
    ent_t e;
    bit   sw;
    swap_req = req;
    @(posedge clk);
    #1;
    if (q.size() == 0) gen_seg();
    e  = q.pop_front();
    sw = e.fs && m_pend;
    if (sw) m_buf = ~m_buf;
    m_pend   = req || (m_pend && !sw);
    last_oen = e.oen;
    if (e.re) exp_addr = int'(m_buf) * NROW * NCOL + m_row * NCOL + int'(e.col);
    if (e.pv) exp_data = (exp_addr * 3) % (1 << DW);
    if (e.lt) exp_row = m_row;
    if (swap_ack) acks_seen++;
    chk("mem_re",      64'(mem_re),      64'(e.re));
    chk("mem_addr",    64'(mem_addr),    64'(exp_addr));
    chk("pix_valid",   64'(pix_valid),   64'(e.pv));
    chk("pix_data",    64'(pix_data),    64'(exp_data));
    chk("sclk",        64'(sclk),        64'(e.sck));
    chk("lat",         64'(lat),         64'(e.lt));
    chk("oe_n",        64'(oe_n),        64'(e.oen));
    chk("row_addr",    64'(row_addr),    64'(exp_row));
    chk("plane",       64'(plane),       64'(m_plane));
    chk("frame_start", 64'(frame_start), 64'(e.fs));
    chk("swap_ack",    64'(swap_ack),    64'(sw));
    chk("buf_sel",     64'(buf_sel),     64'(m_buf));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_mem_re",   64'(mem_re),      64'(0));
    chk("rst_oe_n",     64'(oe_n),        64'(1));
    chk("rst_lat",      64'(lat),         64'(0));
    chk("rst_sclk",     64'(sclk),        64'(0));
    chk("rst_pix",      64'(pix_data),    64'(0));
    chk("rst_pv",       64'(pix_valid),   64'(0));
    chk("rst_buf_sel",  64'(buf_sel),     64'(0));
    chk("rst_swap_ack", 64'(swap_ack),    64'(0));
    chk("rst_fs",       64'(frame_start), 64'(0));
    chk("rst_row_addr", 64'(row_addr),    64'(0));
    chk("rst_plane",    64'(plane),       64'(0));
  endtask

  initial begin
    bit found;
    n_pass = 0; n_checks = 0; acks_seen = 0;
    frame_len = 0;
    for (int p = 0; p < NP; p++) frame_len += (2 * NCOL + 2 + (BC << p)) * NROW;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Two quiet frames: basic scan timing, addresses, data and row latching.
    for (int i = 0; i < 2 * frame_len; i++) cycle(0);

    // Several requests inside one frame collapse into a single swap.
    for (int i = 0; i < 5; i++) cycle(0);
    acks_seen = 0;
    cycle(1); cycle(0); cycle(1); cycle(1);
    for (int i = 0; i < 2 * frame_len; i++) cycle(0);
    chk("collapsed_swaps", 64'(acks_seen), 64'(1));

    // Random request traffic.
    for (int i = 0; i < 400; i++) cycle($urandom_range(0, 19) == 0);

    // Request sampled on the swap edge itself: swap now and again next frame.
    cycle(1);
    found = 0;
    for (int i = 0; i < 2 * frame_len && !found; i++) begin
      if (next_is_fs()) found = 1;
      else cycle(0);
    end
    chk("reach_boundary", 64'(found), 64'(1));
    acks_seen = 0;
    cycle(1);
    for (int i = 0; i < 2 * frame_len; i++) cycle(0);
    chk("coincident_swaps", 64'(acks_seen), 64'(2));

    // Reset in the middle of a display window with a swap pending.
    for (int i = 0; i < 3; i++) cycle(0);
    cycle(1);
    found = 0;
    for (int i = 0; i < 2 * frame_len && !found; i++) begin
      if (!last_oen && m_pend) found = 1;
      else cycle(0);
    end
    chk("reach_display", 64'(found), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    acks_seen = 0;
    for (int i = 0; i < frame_len + frame_len / 2; i++) cycle(0);
    chk("no_swap_after_reset", 64'(acks_seen), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_scan_ctrl.md
Name: led_scan_ctrl

Overview:
Read-side sequencer for the dual-port frame-buffer RAM feeding the LED panel chain. Walks scan row, bit-plane and column, issues read strobes and addresses on the RAM read port, and forwards returned words to the panel shifter. Generates the panel strobes: shift clock, latch, output-enable and row address, with binary-coded-modulation display timing. Owns double-buffer selection and swaps the displayed half only at a frame boundary on request from the writer.

Parameters:
DATA_WIDTH, 64, width of one RAM word / pixel-column word.
COL_BITS, 6, log2 columns per scan row (64 columns).
ROW_BITS, 4, log2 scan rows (16 rows).
PLANES, 8, number of bit-planes per row; legal range 1..16.
BASE_CYCLES, 4, display cycles for plane 0; plane p displays BASE_CYCLES<<p cycles; must be >= 1.

Ports:
clk  input  1  single system clock; also drives the RAM read port clock.
rst  input  1  asynchronous, active-high reset.
mem_re  output  1  RAM read enable.
mem_addr  output  1+ROW_BITS+COL_BITS  RAM read address {buf_sel,row,col}.
mem_dout  input  DATA_WIDTH  RAM read data; valid one cycle after mem_re.
pix_data  output  DATA_WIDTH  registered copy of mem_dout.
pix_valid  output  1  pix_data holds a new column word.
plane  output  4  current bit-plane index, for downstream bit extraction.
sclk  output  1  panel shift clock.
lat  output  1  panel latch strobe.
oe_n  output  1  panel output enable, active low.
row_addr  output  ROW_BITS  row currently driven to the panel.
swap_req  input  1  one-cycle pulse: writer has completed the back buffer.
swap_ack  output  1  one-cycle pulse when the buffers swap.
buf_sel  output  1  buffer half currently displayed.
frame_start  output  1  one-cycle pulse at start of each frame (row 0, plane 0, first read).

Behaviour:
- Reset, asynchronous: state=SHIFT, row=0, plane=0, col=0, buf_sel=0, swap_pending=0.
- Reset values of outputs: all other outputs 0 except oe_n=1. pix_data=0.
- The first frame_start and read occur in the first cycle after rst deasserts.
- SHIFT state: two cycles per column.
  - Even cycle: mem_re=1, mem_addr={buf_sel,row,col}, sclk=0.
  - Odd cycle: pix_valid=1, pix_data=mem_dout, sclk=0.
  - Following even cycle: sclk=1 together with the next read. Data is stable one full cycle before each sclk rise.
  - After col=2^COL_BITS-1 has its pix_valid cycle, go to TAIL. col wraps to 0.
- oe_n=1 throughout SHIFT, TAIL and LATCH; the panel is blanked while shifting.
- TAIL state: 1 cycle, sclk=1 (final shift edge), mem_re=0.
- LATCH state: 1 cycle, lat=1. row_addr<=row on the same edge.
- DISPLAY state: oe_n=0 for exactly BASE_CYCLES<<plane cycles (counter width 4+log2 of max), then the advance step below, then SHIFT.
- Advance step:
  - If plane<PLANES-1: plane+1.
  - Otherwise: plane=0 and row+1.
  - Row wrap from 2^ROW_BITS-1 to 0 is end of frame.
- At end of frame with swap_pending=1: toggle buf_sel, pulse swap_ack, clear swap_pending, all in the same cycle. The next frame reads the new half.
- frame_start pulses with the first mem_re of row 0, plane 0.
- swap_req pulse sets swap_pending. Multiple requests before a boundary collapse into one swap.
- If swap_req arrives in the same cycle as the end-of-frame swap: the swap happens and swap_pending stays 1, so a second swap occurs at the next frame end.
- buf_sel never changes mid-frame.
- mem_addr holds its last value when mem_re=0.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous), a pending swap is discarded, and oe_n goes high at once.

Test Plan:
- Reset release, defaults (COL_BITS=2, ROW_BITS=1, PLANES=2, BASE_CYCLES=2) -> frame_start and mem_re at cycle 1 with addr 0; reads at addr 0,1,2,3 on cycles 1,3,5,7; pix_valid on cycles 2,4,6,8; sclk high on cycles 3,5,7,9; lat on cycle 10; oe_n low on cycles 11–12.
- Full frame, small config -> plane 1 oe_n low for 4 cycles; row_addr goes 0→1 at the second row's latch; reads for row 1 use addresses 4..7; frame_start repeats after row 1, plane 1.
- RAM model returning data = address*3 -> pix_data sequence 0,3,6,9 aligned with pix_valid and unchanged through the following sclk rise.
- swap_req mid-frame, then two more pulses -> exactly one swap_ack at the frame boundary; next frame addresses have MSB=1; no swap at the following boundary.
- swap_req coincident with the frame-boundary swap -> swap at this boundary and again at the next; buf_sel sequence 0→1→0.
- rst asserted during DISPLAY with swap_pending set -> oe_n=1 and lat=0 asynchronously; after release, buf_sel=0, no swap_ack, reads restart at address 0.
